// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: slot states, drop-counter limit, default protected address.
// Pure declarations: no latency, no backpressure.
package regfile_write_arbiter_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic [7:0] DROP_MAX              = 8'hFF;
    localparam int         DEFAULT_PROTECTED_REG = 30;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational arbiter: full-slot vector + pointer -> one-hot grant and index; zero latency, no backpressure.
// Round-robin from i_ptr by default; REGARB_STRICT_PRIO_EN selects fixed priority (requester 0 highest).
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_vld,
    output logic [2:0]         o_grant_idx
);

    int w_start;

`ifdef REGARB_STRICT_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_start      = 0;
`else
    assign w_start      = int'(i_ptr);
`endif

    // First requester at or after the start position wins; the search wraps.
    always_comb begin
        int cand;
        o_grant     = '0;
        o_grant_vld = 1'b0;
        o_grant_idx = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (k + w_start) % NUM_REQ;
            if (!o_grant_vld && i_req[cand]) begin
                o_grant_vld   = 1'b1;
                o_grant[cand] = 1'b1;
                o_grant_idx   = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ one-entry slots; accept->RegWrite is one cycle, slot refills in its grant cycle.
// req_ready low only while a slot is full and not granted (or in reset); REGARB_STRICT_PRIO_EN selects fixed priority.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int PROTECTED_REG = DEFAULT_PROTECTED_REG
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           writeRegister,
    output logic [DATA_W-1:0]           writeData,
    output logic [2:0]                  grant_id,
    output logic [7:0]                  drop_count,
    output logic                        busy
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROTECTED_REG);

    slot_state_t         r_slot_st   [NUM_REQ];
    logic [ADDR_W-1:0]   r_slot_addr [NUM_REQ];
    logic [DATA_W-1:0]   r_slot_data [NUM_REQ];

    logic [NUM_REQ-1:0]  w_full;
    logic [NUM_REQ-1:0]  w_load;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_grant_vld;
    logic [2:0]          w_grant_idx;
    logic [PTR_W-1:0]    w_ptr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_is_prot;
    logic                w_do_write;

    always_comb begin
        w_full = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_full[i] = (r_slot_st[i] == SLOT_FULL);
        end
    end

    // A slot being drained this cycle can take a new entry in the same cycle.
    always_comb begin
        req_ready = '0;
        w_load    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset_n & (~w_full[i] | w_grant[i]);
            w_load[i]    = req_valid[i] & req_ready[i];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req       (w_full),
        .i_ptr       (w_ptr),
        .o_grant     (w_grant),
        .o_grant_vld (w_grant_vld),
        .o_grant_idx (w_grant_idx)
    );

`ifdef REGARB_STRICT_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_grant_vld) begin
            if (w_grant_idx == 3'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= PTR_W'(w_grant_idx + 3'd1);
            end
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_slot_st[i]   <= SLOT_EMPTY;
                r_slot_addr[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_load[i]) begin
                    r_slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                    r_slot_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
                case (r_slot_st[i])
                    SLOT_EMPTY: if (w_load[i]) r_slot_st[i] <= SLOT_FULL;
                    SLOT_FULL:  if (w_grant[i] && !w_load[i]) r_slot_st[i] <= SLOT_EMPTY;
                    default:    r_slot_st[i] <= SLOT_EMPTY;
                endcase
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | r_slot_addr[i];
                w_sel_data = w_sel_data | r_slot_data[i];
            end
        end
    end

    assign w_is_prot  = w_grant_vld & (w_sel_addr == PROT_ADDR);
    assign w_do_write = w_grant_vld & ~w_is_prot;

    // Protected writes still consume the grant; only the register-file strobe is suppressed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            grant_id      <= '0;
            drop_count    <= '0;
        end else begin
            RegWrite <= w_do_write;
            if (w_do_write) begin
                writeRegister <= w_sel_addr;
                writeData     <= w_sel_data;
                grant_id      <= w_grant_idx;
            end
            if (w_is_prot) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    assign busy = (|w_full) | RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed stimulus for regfile_write_arbiter, checked by a queue scoreboard against a slot-level reference model.
module tb_regfile_write_arbiter;

    localparam int N    = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int PROT = 30;

    logic              clock;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              RegWrite;
    logic [AW-1:0]     writeRegister;
    logic [DW-1:0]     writeData;
    logic [2:0]        grant_id;
    logic [7:0]        drop_count;
    logic              busy;

    regfile_write_arbiter #(
        .NUM_REQ       (N),
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .PROTECTED_REG (PROT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .RegWrite      (RegWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .grant_id      (grant_id),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
        int          src;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;

    // Reference model: which slots hold a write, their contents, the next source to favour, drop total.
    bit          m_full [N];
    logic [4:0]  m_addr [N];
    logic [31:0] m_data [N];
    int          m_ptr;
    int          m_drop;
    bit          m_wr;

    bit          s_vld  [N];
    logic [4:0]  s_addr [N];
    logic [31:0] s_data [N];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        int start;
`ifdef REGARB_STRICT_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (m_full[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_ptr  = 0;
        m_drop = 0;
        m_wr   = 1'b0;
        exp_q.delete();
    endfunction

    // Called at a falling edge: check outputs, drive this cycle's requests, advance the model by one edge.
    task automatic step(output logic [N-1:0] acc);
        int          g;
        logic [N-1:0] mr;
        bit          any_full;
        exp_t        e;
        g = model_grant();
        any_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            mr[i] = !m_full[i] || (g == i);
            any_full |= m_full[i];
        end
        check("req_ready", req_ready, mr);
        check("busy", busy, any_full || m_wr);
        check("drop_count", drop_count, m_drop);
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = s_vld[i];
            req_addr[i*AW +: AW]  = s_addr[i];
            req_data[i*DW +: DW]  = s_data[i];
        end
        m_wr = 1'b0;
        if (g >= 0) begin
            if (m_addr[g] == 5'(PROT)) begin
                if (m_drop < 255) m_drop++;
            end else begin
                e.cyc = cyc + 1; e.addr = m_addr[g]; e.data = m_data[g]; e.src = g;
                exp_q.push_back(e);
                m_wr = 1'b1;
            end
            m_full[g] = 1'b0;
            m_ptr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            acc[i] = s_vld[i] && mr[i];
            if (acc[i]) begin
                m_full[i] = 1'b1;
                m_addr[i] = s_addr[i];
                m_data[i] = s_data[i];
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) s_vld[i] = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) s_vld[i] = 1'b0;
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_drop", drop_count, 0);
        check("rst_waddr", writeRegister, 0);
        check("rst_wdata", writeData, 0);
        check("rst_gid", grant_id, 0);
        model_clear();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clock);
    endtask

    // Monitor: every write strobe must match the oldest expected write, at its predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en && reset_n) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    tests++; fails++;
                    $display("FAIL missed_write: src %0d addr %0d expected at cycle %0d", e.src, e.addr, e.cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("regwrite", RegWrite, 1);
                    check("write_addr", writeRegister, e.addr);
                    check("write_data", writeData, e.data);
                    check("grant_id", grant_id, e.src);
                end else begin
                    check("regwrite_idle", RegWrite, 0);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] acc;
        reset_n   = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b0; s_addr[i] = '0; s_data[i] = '0;
        end
        @(negedge clock);
        do_reset();

        // Single source
        s_vld[0] = 1'b1; s_addr[0] = 5'd5; s_data[0] = 32'hDEADBEEF;
        step(acc);
        idle(4);

        // Fairness from pointer 0, all sources continuously valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b1; s_addr[i] = 5'(i + 1); s_data[i] = $urandom;
        end
        repeat (8) begin
            step(acc);
            for (int i = 0; i < N; i++) if (acc[i]) s_data[i] = $urandom;
        end
        idle(5);

        // Protected address: single drop, then saturation
        s_vld[1] = 1'b1; s_addr[1] = 5'(PROT); s_data[1] = 32'h1234;
        step(acc);
        idle(3);
        s_vld[1] = 1'b1;
        repeat (300) begin
            s_data[1] = $urandom;
            step(acc);
        end
        idle(3);
        check("drop_saturated", drop_count, 255);

        // Same address from two sources with the pointer parked at 2
        do_reset();
        s_vld[1] = 1'b1; s_addr[1] = 5'd3; s_data[1] = 32'h33;
        step(acc);
        idle(3);
        s_vld[0] = 1'b1; s_addr[0] = 5'd7; s_data[0] = 32'd1;
        s_vld[2] = 1'b1; s_addr[2] = 5'd7; s_data[2] = 32'd2;
        step(acc);
        idle(5);

        // Reset while a write is on the port and two slots are full
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b1; s_addr[i] = 5'(10 + i); s_data[i] = $urandom;
        end
        step(acc);
        for (int i = 0; i < N; i++) s_vld[i] = 1'b0;
        step(acc);
        check("pre_reset_regwrite", RegWrite, 1);
        do_reset();
        idle(6);

        // Randomised traffic, requests held until accepted
        for (int i = 0; i < N; i++) s_vld[i] = 1'b0;
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (!s_vld[i]) begin
                    s_vld[i]  = ($urandom_range(0, 2) != 0);
                    s_addr[i] = ($urandom_range(0, 5) == 0) ? 5'(PROT) : 5'($urandom_range(0, 31));
                    s_data[i] = $urandom;
                end
            end
            step(acc);
            for (int i = 0; i < N; i++) if (acc[i]) s_vld[i] = 1'b0;
        end
        idle(6);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
